// File: rtl/rle_block_sequencer_pkg.sv
// Shared types for the RLE block sequencer: FSM states, symbol record and
// the two fixed symbols (ZRL, EOB).
package rle_block_sequencer_pkg;
    localparam int BLK_LEN = 64;
    localparam int IDX_W   = $clog2(BLK_LEN);
    localparam logic [3:0] ZRL_RUN = 4'd15;

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [3:0] run;
        logic [7:0] value;
        logic       eob;
    } sym_t;

    localparam sym_t SYM_ZRL = '{run: ZRL_RUN, value: 8'd0, eob: 1'b0};
    localparam sym_t SYM_EOB = '{run: 4'd0,    value: 8'd0, eob: 1'b1};
endpackage

// File: rtl/rle_block_sequencer_if.sv
// Symbol stream towards the Huffman stage: valid/ready handshake.
interface rle_block_sequencer_if;
    logic [3:0] sym_run;
    logic [7:0] sym_value;
    logic       sym_eob;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_run, sym_value, sym_eob, sym_valid, input sym_ready);
    modport slave  (input sym_run, sym_value, sym_eob, sym_valid, output sym_ready);
endinterface

// File: rtl/rle_block_sequencer_skid.sv
// Output holding register plus ZRL-pending counter; a real symbol waits in
// r_hold while the pending ZRLs ahead of it are handed out one by one.
module rle_sym_skid
    import rle_block_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_in_vld,
    input  sym_t i_in,
    input  logic i_eob,
    input  logic i_clr_pend,
    output logic o_stall,
    output logic o_out_free,
    output logic o_empty,
    rle_block_sequencer_if.master sym
);
    sym_t       r_out, r_hold, w_out_n, w_hold_n, w_src;
    logic       r_out_vld, r_hold_vld, w_out_vld_n, w_hold_vld_n;
    logic [1:0] r_pend, w_pend_n;
    logic       w_in_zrl, w_in_sym, w_src_vld;

    assign w_in_zrl   = i_in_vld & (i_in.run == ZRL_RUN) & (i_in.value == 8'd0);
    assign w_in_sym   = i_in_vld & ~w_in_zrl;
    // An incoming symbol never meets a full hold slot: the front end was
    // stalled in every cycle that could have produced one.
    assign w_src_vld  = r_hold_vld | w_in_sym;
    assign w_src      = r_hold_vld ? r_hold : i_in;
    assign o_out_free = ~r_out_vld | sym.sym_ready;
    assign o_stall    = (r_out_vld & ~sym.sym_ready) | ((r_pend != 2'd0) & w_src_vld);
    assign o_empty    = ~r_out_vld & ~r_hold_vld;

    always_comb begin
        w_out_n      = r_out;
        w_out_vld_n  = r_out_vld & ~sym.sym_ready;
        w_hold_n     = r_hold;
        w_hold_vld_n = r_hold_vld;
        w_pend_n     = r_pend;
        if (w_in_zrl && r_pend != 2'd3) w_pend_n = r_pend + 2'd1;
        if (w_in_sym) begin
            w_hold_n     = i_in;
            w_hold_vld_n = 1'b1;
        end
        if (o_out_free) begin
            if (i_eob) begin
                w_out_n     = SYM_EOB;
                w_out_vld_n = 1'b1;
            end else if (w_src_vld && r_pend != 2'd0) begin
                w_out_n     = SYM_ZRL;
                w_out_vld_n = 1'b1;
                w_pend_n    = r_pend - 2'd1;
            end else if (w_src_vld) begin
                w_out_n      = w_src;
                w_out_vld_n  = 1'b1;
                w_hold_vld_n = 1'b0;
            end
        end
        if (i_clr_pend) w_pend_n = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_pend     <= 2'd0;
        end else begin
            r_out      <= w_out_n;
            r_out_vld  <= w_out_vld_n;
            r_hold     <= w_hold_n;
            r_hold_vld <= w_hold_vld_n;
            r_pend     <= w_pend_n;
        end
    end

    assign sym.sym_run   = r_out.run;
    assign sym.sym_value = r_out.value;
    assign sym.sym_eob   = r_out.eob;
    assign sym.sym_valid = r_out_vld;
endmodule

// File: rtl/rle_block_sequencer.sv
// Walks one 8x8 block out of BRAM, peels off DC, feeds AC through the RLE
// engine and hands the symbols to the skid stage; everything freezes on stall.
module rle_block_sequencer
    import rle_block_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int BRAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    input  logic [7:0]        i_bram_dout,
    output logic              o_rle_ce,
    output logic              o_rle_clr,
    output logic [7:0]        o_rle_pixel,
    input  logic [3:0]        i_rle_num_0s,
    input  logic [7:0]        i_rle_value,
    input  logic              i_rle_valid,
    output logic [7:0]        o_dc_value,
    output logic              o_dc_valid,
    rle_block_sequencer_if.master sym
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

    state_t                           r_state, w_next;
    logic [ADDR_W-1:0]                r_base;
    logic [IDX_W-1:0]                 r_idx;
    logic [BRAM_LAT:1]                r_vld_pipe;
    logic [BRAM_LAT:1][IDX_W-1:0]     r_idx_pipe;
    logic                             r_ce_d, r_last_nz, r_eob_done, r_dc_valid;
    logic [7:0]                       r_dc_value;
    logic                             w_stall, w_out_free, w_skid_empty, w_issue, w_dc_cap;
    logic                             w_head_vld, w_pipe_busy, w_eob_push, w_clr_pend, w_in_vld;
    logic [IDX_W-1:0]                 w_head_idx;
    sym_t                             w_in_sym;

    assign w_head_vld  = r_vld_pipe[BRAM_LAT];
    assign w_head_idx  = r_idx_pipe[BRAM_LAT];
    assign w_pipe_busy = |r_vld_pipe;
    assign w_issue     = (r_state == FETCH) & ~w_stall;
    assign w_dc_cap    = ~w_stall & w_head_vld & (w_head_idx == '0);
    assign o_rle_ce    = ~w_stall & w_head_vld & (w_head_idx != '0);
    assign o_rle_pixel = o_rle_ce ? i_bram_dout : 8'd0;
    assign o_rle_clr   = (r_state == CLEAR);
    // BRAM output only moves with bram_en, so it is kept high while draining.
    assign o_bram_en   = ~w_stall & ((r_state == FETCH) | ((r_state == DRAIN) & w_pipe_busy));
    assign o_bram_addr = r_base + ADDR_W'(r_idx);
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_dc_value  = r_dc_value;
    assign o_dc_valid  = r_dc_valid;

    assign w_in_vld   = r_ce_d & i_rle_valid;
    assign w_in_sym   = '{run: i_rle_num_0s, value: i_rle_value, eob: 1'b0};
    assign w_eob_push = (r_state == FLUSH) & ~r_last_nz & ~r_eob_done & w_out_free;
    assign w_clr_pend = (r_state == CLEAR) | (r_state == FLUSH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (i_start) w_next = CLEAR;
            CLEAR: w_next = FETCH;
            FETCH: if (w_issue && r_idx == LAST_IDX) w_next = DRAIN;
            DRAIN: if (!w_pipe_busy && !r_ce_d && w_skid_empty) w_next = FLUSH;
            FLUSH: if ((r_last_nz || r_eob_done) && w_skid_empty) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_idx      <= '0;
            r_vld_pipe <= '0;
            r_idx_pipe <= '0;
            r_ce_d     <= 1'b0;
            r_last_nz  <= 1'b0;
            r_eob_done <= 1'b0;
            r_dc_value <= 8'd0;
            r_dc_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ce_d     <= o_rle_ce;
            r_dc_valid <= w_dc_cap;
            if (r_state == IDLE && i_start) r_base <= i_base_addr;
            if (r_state == CLEAR) begin
                r_idx      <= '0;
                r_last_nz  <= 1'b0;
                r_eob_done <= 1'b0;
            end else begin
                if (w_issue) r_idx <= r_idx + 1'b1;
                if (w_eob_push) r_eob_done <= 1'b1;
                if (o_rle_ce && w_head_idx == LAST_IDX && i_bram_dout != 8'd0) r_last_nz <= 1'b1;
            end
            if (w_dc_cap) r_dc_value <= i_bram_dout;
            if (!w_stall) begin
                for (int s = BRAM_LAT; s > 1; s--) begin
                    r_vld_pipe[s] <= r_vld_pipe[s-1];
                    r_idx_pipe[s] <= r_idx_pipe[s-1];
                end
                r_vld_pipe[1] <= w_issue;
                r_idx_pipe[1] <= r_idx;
            end
        end
    end

    rle_sym_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_in_vld   (w_in_vld),
        .i_in       (w_in_sym),
        .i_eob      (w_eob_push),
        .i_clr_pend (w_clr_pend),
        .o_stall    (w_stall),
        .o_out_free (w_out_free),
        .o_empty    (w_skid_empty),
        .sym        (sym)
    );
endmodule

// File: tb/tb_rle_block_sequencer.sv
// Bench: BRAM and RLE-engine models around the sequencer, JPEG reference
// encoder fills a symbol scoreboard, outputs compared on the falling edge.
module tb_rle_block_sequencer;
    logic        clk, rst, start, busy, done, bram_en, rle_ce, rle_clr, dc_valid;
    logic [9:0]  base_addr, bram_addr;
    logic [7:0]  bram_dout, rle_pixel, dc_value;
    logic [3:0]  rle_n0 = 4'd0, m_run = 4'd0;
    logic [7:0]  rle_val = 8'd0, bq1 = 8'd0, bq2 = 8'd0;
    logic        rle_vld = 1'b0;
    logic [7:0]  mem [0:1023];
    logic [7:0]  blk [64];
    logic [12:0] exp_q[$];
    logic [7:0]  dc_q[$];
    logic [12:0] m_e;
    logic [7:0]  m_d;
    int          total = 0, bad = 0, done_cnt = 0, en_viol = 0, ready_mode = 0;

    rle_block_sequencer_if sif();

    rle_block_sequencer dut (
        .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr),
        .o_busy(busy), .o_done(done), .o_bram_en(bram_en), .o_bram_addr(bram_addr),
        .i_bram_dout(bram_dout), .o_rle_ce(rle_ce), .o_rle_clr(rle_clr),
        .o_rle_pixel(rle_pixel), .i_rle_num_0s(rle_n0), .i_rle_value(rle_val),
        .i_rle_valid(rle_vld), .o_dc_value(dc_value), .o_dc_valid(dc_valid), .sym(sif)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    // BRAM: two registered stages, frozen while bram_en is low
    always @(posedge clk) if (bram_en) begin bq1 <= mem[bram_addr]; bq2 <= bq1; end
    assign bram_dout = bq2;

    // RLE engine: 16th consecutive zero yields (15,0); nonzero yields (run,val)
    always @(posedge clk) begin
        if (rle_clr) begin m_run <= 4'd0; rle_vld <= 1'b0; end
        else if (rle_ce) begin
            if (rle_pixel == 8'd0) begin
                if (m_run == 4'd15) begin rle_n0 <= 4'd15; rle_val <= 8'd0; rle_vld <= 1'b1; m_run <= 4'd0; end
                else begin m_run <= m_run + 4'd1; rle_vld <= 1'b0; end
            end else begin
                rle_n0 <= m_run; rle_val <= rle_pixel; rle_vld <= 1'b1; m_run <= 4'd0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        sif.sym_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: sif.sym_ready = ~sif.sym_ready;
                2: sif.sym_ready = 1'($urandom_range(0, 1));
                default: sif.sym_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) if (rst) begin
        if (sif.sym_valid && sif.sym_ready) begin
            if (exp_q.size() == 0) chk("sym_extra", exp_q.size(), 1);
            else begin
                m_e = exp_q.pop_front();
                chk("sym", {sif.sym_run, sif.sym_value, sif.sym_eob}, m_e);
            end
        end
        if (dc_valid) begin
            if (dc_q.size() == 0) chk("dc_extra", dc_q.size(), 1);
            else begin m_d = dc_q.pop_front(); chk("dc", dc_value, m_d); end
        end
        if (done) done_cnt++;
        if (sif.sym_valid && !sif.sym_ready && bram_en) en_viol++;
    end

    // Reference JPEG AC coding of blk[1..63]
    task automatic push_exp();
        int run;
        run = 0;
        for (int k = 1; k < 64; k++) begin
            if (blk[k] == 8'd0) run++;
            else begin
                while (run > 15) begin exp_q.push_back({4'd15, 8'd0, 1'b0}); run -= 16; end
                exp_q.push_back({4'(run), blk[k], 1'b0});
                run = 0;
            end
        end
        if (blk[63] == 8'd0) exp_q.push_back({4'd0, 8'd0, 1'b1});
    endtask

    task automatic fill(input logic [7:0] dc, input int lo, input int hi, input logic [7:0] v);
        blk[0] = dc;
        for (int k = 1; k < 64; k++) blk[k] = (k >= lo && k <= hi) ? v : 8'd0;
    endtask

    task automatic start_block(input logic [9:0] base);
        for (int k = 0; k < 64; k++) mem[base + 10'(k)] = blk[k];
        dc_q.push_back(blk[0]);
        @(posedge clk); #1;
        base_addr = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_block(input logic [9:0] base, input int rmode);
        int lat, cyc, d0;
        push_exp();
        ready_mode = rmode;
        en_viol = 0;
        d0 = done_cnt;
        start_block(base);
        lat = 1;
        while (!bram_en && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("start_lat", lat, 2);
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        chk("done_seen", done_cnt - d0, 1);
        @(posedge clk); #1;
        chk("done_once", done_cnt - d0, 1);
        chk("busy_after", busy, 0);
        chk("sym_left", exp_q.size(), 0);
        chk("dc_left", dc_q.size(), 0);
        chk("stall_bram_en", en_viol, 0);
        ready_mode = 0;
    endtask

    initial begin
        int cyc, d0;
        rst = 1'b0; start = 1'b0; base_addr = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'hAA;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_sym_valid", sif.sym_valid, 0);
        chk("rst_dc_valid", dc_valid, 0);
        @(posedge clk); #1; rst = 1'b1;

        fill(8'h12, 1, 0, 8'd0);                 run_block(10'h040, 0);
        fill(8'h34, 1, 0, 8'd0); blk[1] = 8'd3; blk[3] = 8'hFE;
                                                 run_block(10'h100, 0);
        fill(8'h05, 21, 21, 8'd5);               run_block(10'h180, 0);
        fill(8'hF0, 63, 63, 8'd7);               run_block(10'h200, 0);
        fill(8'h01, 1, 10, 8'd1);                run_block(10'h280, 1);
        blk[0] = 8'h77;
        for (int k = 1; k < 64; k++) blk[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        run_block(10'h300, 2);

        // Abort mid-block, then the first block again
        fill(8'h12, 1, 0, 8'd0);
        d0 = done_cnt;
        start_block(10'h380);
        cyc = 0;
        while (!(bram_en && bram_addr == 10'h380 + 10'd30) && cyc < 500) begin @(posedge clk); #1; cyc++; end
        chk("abort_reach", bram_addr, 10'h380 + 10'd30);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_bram_en", bram_en, 0);
        chk("abort_sym_valid", sif.sym_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_dc_left", dc_q.size(), 0);
        exp_q.delete();
        fill(8'h12, 1, 0, 8'd0);                 run_block(10'h040, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
